// File: rtl/alu_mdu_seq.sv
// Multi-cycle RV32IM-style ALU with pipelined multiplier and radix-2 restoring divider.
// Single-cycle ops answer one cycle after START; MUL*/DIV* hold BUSY until RESULT_VALID.
module alu_mdu_seq #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       select,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result
);

  localparam int SHW = $clog2(WIDTH);
  localparam int PW  = 2 * WIDTH;
  localparam logic [SHW-1:0]   DIV_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0]   DIV_ONE  = SHW'(1);
  localparam logic [1:0]       MUL_LAST = 2'(MUL_LATENCY - 1);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  function automatic logic [WIDTH-1:0] neg_if(input logic en, input logic [WIDTH-1:0] v);
    return en ? (ZERO - v) : v;
  endfunction

  state_t           state_r, state_next_s;
  logic [WIDTH-1:0] result_r, res_next_s;
  logic             valid_r, valid_next_s;
  logic             busy_r, busy_next_s;

  logic [WIDTH-1:0] alu_s;
  logic [SHW-1:0]   shamt_s;

  logic signed [WIDTH:0] mul_a_s, mul_b_s;
  logic [PW-1:0]    prod_s;
  logic [PW-1:0]    prod_r [MUL_LATENCY];
  logic [1:0]       mul_cnt_r;
  logic             mul_hi_r;

  logic             is_mul_s, is_div_s, div_rem_s;
  logic             div_zero_s, div_ovf_s;
  logic             dvd_neg_s, dvs_neg_s;
  logic [WIDTH-1:0] div_special_s;
  logic [WIDTH-1:0] quo_r, rem_r, dvs_r;
  logic [SHW-1:0]   div_cnt_r;
  logic             neg_quo_r, neg_rem_r, is_rem_r;
  logic [WIDTH:0]   shift_s;
  logic             fits_s;
  logic [WIDTH-1:0] rem_step_s;
  logic [WIDTH-1:0] fix_s;
  logic             accept_s;

  assign shamt_s  = data2[SHW-1:0];
  assign accept_s = start & (state_r == IDLE);

  // Single-cycle operation result
  always_comb begin
    alu_s = ZERO;
    casez (select)
      6'b000000: alu_s = data1 + data2;
      6'b000001: alu_s = data1 << shamt_s;
      6'b000010: alu_s = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
      6'b000011: alu_s = {{(WIDTH-1){1'b0}}, (data1 < data2)};
      6'b000100: alu_s = data1 ^ data2;
      6'b000101: alu_s = data1 >> shamt_s;
      6'b000110: alu_s = data1 | data2;
      6'b000111: alu_s = data1 & data2;
      6'b010000: alu_s = data1 - data2;
      6'b010101: alu_s = $signed(data1) >>> shamt_s;
      6'b011???: alu_s = data2;
      default:   alu_s = ZERO;
    endcase
  end

  // MUL/MULH are signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned.
  // Sign-extending to 2*WIDTH makes the low 2*WIDTH product bits exact for every mix.
  assign is_mul_s = (select[5:2] == 4'b0010);
  assign mul_a_s  = {(select[1:0] != 2'b11) & data1[WIDTH-1], data1};
  assign mul_b_s  = {~select[1] & data2[WIDTH-1], data2};
  assign prod_s   = PW'(mul_a_s) * PW'(mul_b_s);

  assign is_div_s      = (select[5:2] == 4'b0011);
  assign div_rem_s     = select[1];
  assign div_zero_s    = (data2 == ZERO);
  assign div_ovf_s     = ~select[0] & (data1 == MIN_NEG) & (data2 == ALL_ONES);
  assign dvd_neg_s     = ~select[0] & data1[WIDTH-1];
  assign dvs_neg_s     = ~select[0] & data2[WIDTH-1];
  assign div_special_s = div_zero_s ? (div_rem_s ? data1 : ALL_ONES)
                                    : (div_rem_s ? ZERO  : data1);

  // One restoring step: the shifted partial remainder can exceed WIDTH bits only when it fits
  assign shift_s    = {rem_r, quo_r[WIDTH-1]};
  assign fits_s     = shift_s[WIDTH] | (shift_s[WIDTH-1:0] >= dvs_r);
  assign rem_step_s = fits_s ? (shift_s[WIDTH-1:0] - dvs_r) : shift_s[WIDTH-1:0];
  assign fix_s      = is_rem_r ? neg_if(neg_rem_r, rem_r) : neg_if(neg_quo_r, quo_r);

  // Next-state and next-result decode
  always_comb begin
    state_next_s = state_r;
    res_next_s   = result_r;
    valid_next_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (is_mul_s) begin
            state_next_s = MUL;
          end else if (is_div_s && !(div_zero_s || div_ovf_s)) begin
            state_next_s = DIV;
          end else if (is_div_s) begin
            res_next_s   = div_special_s;
            valid_next_s = 1'b1;
          end else begin
            res_next_s   = alu_s;
            valid_next_s = 1'b1;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      MUL: begin
        if (mul_cnt_r == MUL_LAST) begin
          state_next_s = IDLE;
          res_next_s   = mul_hi_r ? prod_r[MUL_LATENCY-1][PW-1:WIDTH]
                                  : prod_r[MUL_LATENCY-1][WIDTH-1:0];
          valid_next_s = 1'b1;
        end else begin
          state_next_s = MUL;
        end
      end
      DIV: begin
        if (div_cnt_r == DIV_LAST) begin
          state_next_s = FIX;
        end else begin
          state_next_s = DIV;
        end
      end
      FIX: begin
        state_next_s = IDLE;
        res_next_s   = fix_s;
        valid_next_s = 1'b1;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  assign busy_next_s = (state_next_s != IDLE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Output, multiplier pipeline and divider datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r  <= ZERO;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      mul_cnt_r <= 2'd0;
      mul_hi_r  <= 1'b0;
      for (int i = 0; i < MUL_LATENCY; i++) begin
        prod_r[i] <= {PW{1'b0}};
      end
      quo_r     <= ZERO;
      rem_r     <= ZERO;
      dvs_r     <= ZERO;
      div_cnt_r <= {SHW{1'b0}};
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      is_rem_r  <= 1'b0;
    end else begin
      result_r  <= res_next_s;
      valid_r   <= valid_next_s;
      busy_r    <= busy_next_s;
      prod_r[0] <= prod_s;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        prod_r[i] <= prod_r[i-1];
      end
      if (accept_s) begin
        mul_cnt_r <= 2'd0;
        mul_hi_r  <= (select[1:0] != 2'b00);
        quo_r     <= neg_if(dvd_neg_s, data1);
        rem_r     <= ZERO;
        dvs_r     <= neg_if(dvs_neg_s, data2);
        div_cnt_r <= {SHW{1'b0}};
        neg_quo_r <= dvd_neg_s ^ dvs_neg_s;
        neg_rem_r <= dvd_neg_s;
        is_rem_r  <= div_rem_s;
      end else begin
        case (state_r)
          MUL: mul_cnt_r <= mul_cnt_r + 2'd1;
          DIV: begin
            quo_r     <= {quo_r[WIDTH-2:0], fits_s};
            rem_r     <= rem_step_s;
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
          default: mul_cnt_r <= mul_cnt_r;
        endcase
      end
    end
  end

  assign busy         = busy_r;
  assign result_valid = valid_r;
  assign result       = result_r;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed self-checking bench for alu_mdu_seq (WIDTH=32, MUL_LATENCY 1 and 3).
module tb_alu_mdu_seq;

  localparam logic [5:0] OP_ADD    = 6'b000000;
  localparam logic [5:0] OP_SLL    = 6'b000001;
  localparam logic [5:0] OP_SLT    = 6'b000010;
  localparam logic [5:0] OP_SLTU   = 6'b000011;
  localparam logic [5:0] OP_XOR    = 6'b000100;
  localparam logic [5:0] OP_SRL    = 6'b000101;
  localparam logic [5:0] OP_OR     = 6'b000110;
  localparam logic [5:0] OP_AND    = 6'b000111;
  localparam logic [5:0] OP_MUL    = 6'b001000;
  localparam logic [5:0] OP_MULH   = 6'b001001;
  localparam logic [5:0] OP_MULHSU = 6'b001010;
  localparam logic [5:0] OP_MULHU  = 6'b001011;
  localparam logic [5:0] OP_DIV    = 6'b001100;
  localparam logic [5:0] OP_DIVU   = 6'b001101;
  localparam logic [5:0] OP_REM    = 6'b001110;
  localparam logic [5:0] OP_REMU   = 6'b001111;
  localparam logic [5:0] OP_SUB    = 6'b010000;
  localparam logic [5:0] OP_SRA    = 6'b010101;
  localparam logic [5:0] OP_FWD    = 6'b011000;
  localparam logic [5:0] OP_FWD7   = 6'b011111;
  localparam logic [5:0] OP_UNDEF  = 6'b010001;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  sel;
  logic [31:0] d1, d2;
  logic        busy1, valid1, busy3, valid3;
  logic [31:0] res1, res3;
  int          passed;
  int          total;

  alu_mdu_seq #(.WIDTH(32), .MUL_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .select(sel), .data1(d1), .data2(d2),
    .busy(busy1), .result_valid(valid1), .result(res1)
  );

  alu_mdu_seq #(.WIDTH(32), .MUL_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .select(sel), .data1(d1), .data2(d2),
    .busy(busy3), .result_valid(valid3), .result(res3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; sel = OP_ADD; d1 = 32'h1; d2 = 32'h2;
    repeat (2) @(negedge clk);
    total++;
    if ({valid1, busy1, res1} !== {1'b0, 1'b0, 32'h0}) begin
      $display("FAIL reset_dut1: got v=%b b=%b r=%h want v=0 b=0 r=00000000", valid1, busy1, res1);
    end else passed++;
    total++;
    if ({valid3, busy3, res3} !== {1'b0, 1'b0, 32'h0}) begin
      $display("FAIL reset_dut3: got v=%b b=%b r=%h want v=0 b=0 r=00000000", valid3, busy3, res3);
    end else passed++;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    total++;
    if ({valid1, busy1, res1} !== {1'b0, 1'b0, 32'h0}) begin
      $display("FAIL reset_idle: got v=%b b=%b r=%h want v=0 b=0 r=00000000", valid1, busy1, res1);
    end else passed++;
  endtask

  task automatic test_single();
    logic [5:0]  ops  [14];
    logic [31:0] as   [14];
    logic [31:0] bs   [14];
    logic [31:0] exps [14];
    ops  = '{OP_ADD, OP_SUB, OP_SRA, OP_SRL, OP_SLT, OP_SLTU, OP_FWD,
             OP_SLL, OP_XOR, OP_OR, OP_AND, OP_UNDEF, OP_SRA, OP_FWD7};
    as   = '{32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff, 32'h00000000,
             32'h00000001, 32'hf0f0f0f0, 32'hf0f0f0f0, 32'hf0f0f0f0, 32'hffffffff, 32'h80000000, 32'h12345678};
    bs   = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001, 32'hffffffff,
             32'h00000021, 32'hff00ff00, 32'hff00ff00, 32'hff00ff00, 32'hffffffff, 32'h000000e4, 32'hcafef00d};
    exps = '{32'h00000000, 32'hfffffffe, 32'hffffffff, 32'h7fffffff, 32'h00000001, 32'h00000000, 32'hffffffff,
             32'h00000002, 32'h0ff00ff0, 32'hfff0fff0, 32'hf000f000, 32'h00000000, 32'hf8000000, 32'hcafef00d};
    start = 1'b1;
    for (int i = 0; i < 14; i++) begin
      sel = ops[i]; d1 = as[i]; d2 = bs[i];
      @(negedge clk);
      total++;
      if ({valid1, busy1, res1} !== {1'b1, 1'b0, exps[i]}) begin
        $display("FAIL single[%0d] op=%b: got v=%b b=%b r=%h want v=1 b=0 r=%h",
                 i, ops[i], valid1, busy1, res1, exps[i]);
      end else passed++;
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [5:0]  ops  [4];
    logic [31:0] as   [4];
    logic [31:0] bs   [4];
    logic [31:0] exps [4];
    ops  = '{OP_MULHSU, OP_MULH, OP_MULHU, OP_MUL};
    as   = '{32'h80000000, 32'haaaaaaab, 32'haaaaaaab, 32'hffffffff};
    bs   = '{32'hffff8000, 32'h0002fe7d, 32'h0002fe7d, 32'hffffffff};
    exps = '{32'h80004000, 32'hffff0081, 32'h0001fefe, 32'h00000001};
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; sel = ops[i]; d1 = as[i]; d2 = bs[i];
      @(negedge clk);
      start = 1'b0; sel = OP_ADD; d1 = 32'h0; d2 = 32'h0;
      total++;
      if ({valid1, busy1} !== 2'b01) begin
        $display("FAIL mul_busy[%0d]: got v=%b b=%b want v=0 b=1", i, valid1, busy1);
      end else passed++;
      @(negedge clk);
      total++;
      if ({valid1, busy1, res1} !== {1'b1, 1'b0, exps[i]}) begin
        $display("FAIL mul[%0d]: got v=%b b=%b r=%h want v=1 b=0 r=%h", i, valid1, busy1, res1, exps[i]);
      end else passed++;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_mul_lat3();
    logic [5:0]  ops  [2];
    logic [31:0] as   [2];
    logic [31:0] bs   [2];
    logic [31:0] exps [2];
    ops  = '{OP_MULHSU, OP_MULHU};
    as   = '{32'h80000000, 32'haaaaaaab};
    bs   = '{32'hffff8000, 32'h0002fe7d};
    exps = '{32'h80004000, 32'h0001fefe};
    for (int i = 0; i < 2; i++) begin
      start = 1'b1; sel = ops[i]; d1 = as[i]; d2 = bs[i];
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        start = 1'b0; d1 = 32'h0; d2 = 32'h0;
        total++;
        if ({valid3, busy3} !== 2'b01) begin
          $display("FAIL mul3_busy[%0d] N+%0d: got v=%b b=%b want v=0 b=1", i, k, valid3, busy3);
        end else passed++;
      end
      @(negedge clk);
      total++;
      if ({valid3, busy3, res3} !== {1'b1, 1'b0, exps[i]}) begin
        $display("FAIL mul3[%0d]: got v=%b b=%b r=%h want v=1 b=0 r=%h", i, valid3, busy3, res3, exps[i]);
      end else passed++;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_div();
    logic [5:0]  ops  [8];
    logic [31:0] as   [8];
    logic [31:0] bs   [8];
    logic [31:0] exps [8];
    logic        win_ok;
    ops  = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIVU, OP_DIV};
    as   = '{32'hffffffff, 32'hfffffff9, 32'hffffffff, 32'h00000003,
             32'h00000064, 32'h00000064, 32'hfffffff9, 32'hfffffff9};
    bs   = '{32'h00000001, 32'h00000002, 32'h00000001, 32'h00000002,
             32'hfffffff9, 32'hfffffff9, 32'h00000002, 32'hfffffffe};
    exps = '{32'hffffffff, 32'hffffffff, 32'hffffffff, 32'h00000001,
             32'hfffffff2, 32'h00000002, 32'h7ffffffc, 32'h00000003};
    for (int i = 0; i < 8; i++) begin
      start = 1'b1; sel = ops[i]; d1 = as[i]; d2 = bs[i];
      win_ok = 1'b1;
      for (int k = 1; k <= 33; k++) begin
        @(negedge clk);
        start = 1'b0; sel = OP_MULHU; d1 = 32'h5a5a5a5a; d2 = 32'h0;
        if ({valid1, busy1} !== 2'b01) win_ok = 1'b0;
      end
      total++;
      if (win_ok !== 1'b1) begin
        $display("FAIL div_busy[%0d]: BUSY low or RESULT_VALID high within N+1..N+33", i);
      end else passed++;
      @(negedge clk);
      total++;
      if ({valid1, busy1, res1} !== {1'b1, 1'b0, exps[i]}) begin
        $display("FAIL div[%0d] op=%b: got v=%b b=%b r=%h want v=1 b=0 r=%h",
                 i, ops[i], valid1, busy1, res1, exps[i]);
      end else passed++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_corner();
    logic [5:0]  ops  [6];
    logic [31:0] as   [6];
    logic [31:0] bs   [6];
    logic [31:0] exps [6];
    ops  = '{OP_DIV, OP_REMU, OP_DIV, OP_REM, OP_DIVU, OP_REM};
    as   = '{32'h5, 32'h5, 32'h80000000, 32'h80000000, 32'h5, 32'h5};
    bs   = '{32'h0, 32'h0, 32'hffffffff, 32'hffffffff, 32'h0, 32'h0};
    exps = '{32'hffffffff, 32'h00000005, 32'h80000000, 32'h00000000, 32'hffffffff, 32'h00000005};
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sel = ops[i]; d1 = as[i]; d2 = bs[i];
      @(negedge clk);
      total++;
      if ({valid1, busy1, res1} !== {1'b1, 1'b0, exps[i]}) begin
        $display("FAIL corner[%0d] op=%b: got v=%b b=%b r=%h want v=1 b=0 r=%h",
                 i, ops[i], valid1, busy1, res1, exps[i]);
      end else passed++;
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_handshake();
    logic win_ok;
    start = 1'b1; sel = OP_DIV; d1 = 32'd100; d2 = 32'd7;
    win_ok = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if ({valid1, busy1} !== 2'b01) win_ok = 1'b0;
      if (k == 1) begin
        start = 1'b1; sel = OP_ADD; d1 = 32'h1; d2 = 32'h2;
      end else begin
        start = 1'b0;
      end
    end
    total++;
    if (win_ok !== 1'b1) begin
      $display("FAIL hs_ignore: ADD during BUSY produced a result or dropped BUSY");
    end else passed++;
    @(negedge clk);
    total++;
    if ({valid1, busy1, res1} !== {1'b1, 1'b0, 32'h0000000e}) begin
      $display("FAIL hs_div: got v=%b b=%b r=%h want v=1 b=0 r=0000000e", valid1, busy1, res1);
    end else passed++;
    start = 1'b1; sel = OP_ADD; d1 = 32'h1; d2 = 32'h2;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({valid1, busy1, res1} !== {1'b1, 1'b0, 32'h00000003}) begin
      $display("FAIL hs_add: got v=%b b=%b r=%h want v=1 b=0 r=00000003", valid1, busy1, res1);
    end else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic quiet;
    start = 1'b1; sel = OP_DIV; d1 = 32'hffffffff; d2 = 32'h1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    total++;
    if ({valid1, busy1} !== 2'b01) begin
      $display("FAIL rst_pre: got v=%b b=%b want v=0 b=1", valid1, busy1);
    end else passed++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({valid1, busy1, res1} !== {1'b0, 1'b0, 32'h0}) begin
      $display("FAIL rst_mid: got v=%b b=%b r=%h want v=0 b=0 r=00000000", valid1, busy1, res1);
    end else passed++;
    quiet = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (valid1 !== 1'b0 || busy1 !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) begin
      $display("FAIL rst_abort: aborted DIV still produced BUSY or RESULT_VALID");
    end else passed++;
    start = 1'b1; sel = OP_MUL; d1 = 32'h00007e00; d2 = 32'hb6db6db7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if ({valid1, busy1, res1} !== {1'b1, 1'b0, 32'h00001200}) begin
      $display("FAIL rst_mul: got v=%b b=%b r=%h want v=1 b=0 r=00001200", valid1, busy1, res1);
    end else passed++;
    repeat (2) @(negedge clk);
    total++;
    if ({valid3, busy3, res3} !== {1'b1, 1'b0, 32'h00001200}) begin
      $display("FAIL rst_mul3: got v=%b b=%b r=%h want v=1 b=0 r=00001200", valid3, busy3, res3);
    end else passed++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    start  = 1'b0;
    sel    = OP_ADD;
    d1     = 32'h0;
    d2     = 32'h0;
    test_reset();
    test_single();
    test_mul();
    test_mul_lat3();
    test_div();
    test_corner();
    test_handshake();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
